bp_gshare_multi: RTL

Parametrised successor to the 2-lane bimodal branch predictor. Adds gshare indexing (PC xor global history), a tagged BTB, and speculative global-history checkpoint/restore. Supports NUM_SUPER fetch lanes and NUM_BR / NUM_LD rollback sources, selecting the oldest by ROB distance. Sits between the F-stage, the branch FUs and the LQ, and drives the pipeline rollback.

---
 rtl/bp_gshare_multi.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/bp_gshare_multi.sv
// Multi-lane gshare branch predictor with tagged BTB, speculative global
// history, and oldest-first rollback selection across branch and load ports.
module bp_gshare_multi #(
  parameter int NUM_SUPER    = 2,
  parameter int NUM_BR       = 2,
  parameter int NUM_LD       = 2,
  parameter int NUM_ROB      = 32,
  parameter int NUM_FL       = 32,
  parameter int NUM_LSQ      = 8,
  parameter int PHT_IDX_BITS = 6,
  parameter int GHR_BITS     = 6,
  parameter int BTB_IDX_BITS = 5,
  parameter int BTB_TAG_BITS = 8,
  localparam int ROB_W = $clog2(NUM_ROB),
  localparam int FL_W  = $clog2(NUM_FL),
  localparam int LSQ_W = $clog2(NUM_LSQ)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_SUPER-1:0][63:0]           if_NPC_out,
  input  logic [NUM_SUPER-1:0][31:0]           if_IR_out,
  input  logic [NUM_SUPER-1:0]                 if_valid,
  input  logic [ROB_W-1:0]                     ROB_tail_idx,
  input  logic [NUM_BR-1:0]                    br_done,
  input  logic [NUM_BR-1:0]                    br_taken,
  input  logic [NUM_BR-1:0]                    br_is_cond,
  input  logic [NUM_BR-1:0][63:0]              br_NPC,
  input  logic [NUM_BR-1:0][63:0]              br_target_PC,
  input  logic [NUM_BR-1:0][63:0]              br_pred_target,
  input  logic [NUM_BR-1:0][GHR_BITS-1:0]      br_ghr,
  input  logic [NUM_BR-1:0][ROB_W-1:0]         br_ROB_idx,
  input  logic [NUM_BR-1:0][FL_W-1:0]          br_FL_idx,
  input  logic [NUM_BR-1:0][LSQ_W-1:0]         br_SQ_idx,
  input  logic [NUM_BR-1:0][LSQ_W-1:0]         br_LQ_idx,
  input  logic [NUM_LD-1:0]                    ld_violate,
  input  logic [NUM_LD-1:0][63:0]              ld_target_PC,
  input  logic [NUM_LD-1:0][GHR_BITS-1:0]      ld_ghr,
  input  logic [NUM_LD-1:0][ROB_W-1:0]         ld_ROB_idx,
  input  logic [NUM_LD-1:0][FL_W-1:0]          ld_FL_idx,
  input  logic [NUM_LD-1:0][LSQ_W-1:0]         ld_SQ_idx,
  input  logic [NUM_LD-1:0][LSQ_W-1:0]         ld_LQ_idx,
  output logic [NUM_SUPER-1:0]                 take_branch_out,
  output logic [NUM_SUPER-1:0]                 inst_valid_out,
  output logic [63:0]                          take_branch_target_out,
  output logic [NUM_SUPER-1:0][GHR_BITS-1:0]   ghr_out,
  output logic                                 rollback_en,
  output logic [ROB_W-1:0]                     ROB_rollback_idx,
  output logic [FL_W-1:0]                      FL_rollback_idx,
  output logic [LSQ_W-1:0]                     SQ_rollback_idx,
  output logic [LSQ_W-1:0]                     LQ_rollback_idx,
  output logic [ROB_W-1:0]                     diff_ROB
);

  localparam logic [5:0] OP_BR   = 6'h30;
  localparam logic [5:0] OP_BSR  = 6'h34;
  localparam logic [5:0] OP_JSR  = 6'h1A;
  localparam logic [5:0] OP_BLBC = 6'h38;
  localparam logic [5:0] OP_BGT  = 6'h3F;

  logic [1:0]              pht_q     [2**PHT_IDX_BITS];
  logic                    btb_v_q   [2**BTB_IDX_BITS];
  logic [BTB_TAG_BITS-1:0] btb_tag_q [2**BTB_IDX_BITS];
  logic [63:0]             btb_tgt_q [2**BTB_IDX_BITS];
  logic [GHR_BITS-1:0]     ghr_q, ghr_d, ghr_fetch;

  logic [NUM_BR-1:0][63:0]               br_eff;
  logic [NUM_BR-1:0]                     br_mis;
  logic [NUM_BR-1:0]                     br_train;
  logic [NUM_BR-1:0][ROB_W-1:0]          br_dist;
  logic [NUM_BR-1:0][PHT_IDX_BITS-1:0]   br_pht_idx;
  logic [NUM_BR-1:0][BTB_IDX_BITS-1:0]   br_btb_idx;
  logic [NUM_BR-1:0][BTB_TAG_BITS-1:0]   br_tag;
  logic [NUM_LD-1:0][ROB_W-1:0]          ld_dist;

  logic                rb_en;
  logic [ROB_W-1:0]    win_dist;
  logic                win_cond, win_taken;
  logic [GHR_BITS-1:0] win_ghr;
  logic [63:0]         rb_target;

  // Only a few IR/NPC bit fields feed the decode and index logic.
  logic unused_bits;
  assign unused_bits = ^{if_IR_out, if_NPC_out, br_NPC};

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    else   return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Per-branch-port resolution: effective target, mispredict, age and table indices.
  always_comb begin
    br_eff = '0; br_mis = '0; br_dist = '0;
    br_pht_idx = '0; br_btb_idx = '0; br_tag = '0; ld_dist = '0;
    for (int k = 0; k < NUM_BR; k++) begin
      br_eff[k]     = br_taken[k] ? br_target_PC[k] : br_NPC[k];
      br_mis[k]     = br_done[k] && (br_eff[k] != br_pred_target[k]);
      br_dist[k]    = ROB_tail_idx - br_ROB_idx[k];
      br_pht_idx[k] = br_NPC[k][PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(br_ghr[k]);
      br_btb_idx[k] = br_NPC[k][BTB_IDX_BITS+1:2];
      br_tag[k]     = br_NPC[k][BTB_IDX_BITS+BTB_TAG_BITS+1:BTB_IDX_BITS+2];
    end
    for (int j = 0; j < NUM_LD; j++) ld_dist[j] = ROB_tail_idx - ld_ROB_idx[j];
  end

  // Oldest-candidate selection; strict compare gives branches and low ports the tie.
  always_comb begin
    rb_en = 1'b0; win_dist = '0; win_cond = 1'b0; win_taken = 1'b0;
    win_ghr = '0; rb_target = '0;
    ROB_rollback_idx = '0; FL_rollback_idx = '0;
    SQ_rollback_idx = '0; LQ_rollback_idx = '0;
    for (int k = 0; k < NUM_BR; k++) begin
      if (br_mis[k] && (!rb_en || (br_dist[k] > win_dist))) begin
        rb_en = 1'b1; win_dist = br_dist[k];
        win_cond = br_is_cond[k]; win_taken = br_taken[k];
        win_ghr = br_ghr[k]; rb_target = br_eff[k];
        ROB_rollback_idx = br_ROB_idx[k]; FL_rollback_idx = br_FL_idx[k];
        SQ_rollback_idx = br_SQ_idx[k]; LQ_rollback_idx = br_LQ_idx[k];
      end
    end
    for (int j = 0; j < NUM_LD; j++) begin
      if (ld_violate[j] && (!rb_en || (ld_dist[j] > win_dist))) begin
        rb_en = 1'b1; win_dist = ld_dist[j];
        win_cond = 1'b0; win_taken = 1'b0;
        win_ghr = ld_ghr[j]; rb_target = ld_target_PC[j];
        ROB_rollback_idx = ld_ROB_idx[j]; FL_rollback_idx = ld_FL_idx[j];
        SQ_rollback_idx = ld_SQ_idx[j]; LQ_rollback_idx = ld_LQ_idx[j];
      end
    end
    diff_ROB = ROB_tail_idx - ROB_rollback_idx;
  end

  assign rollback_en = rb_en;

  // Fetch-side prediction: per-lane history, gshare lookup, first-taken redirect.
  always_comb begin : fetch_comb
    logic [GHR_BITS-1:0]     h;
    logic                    found, cond, unc, dec, hit;
    logic [5:0]              opc;
    logic [PHT_IDX_BITS-1:0] pi;
    logic [BTB_IDX_BITS-1:0] bi;
    h = ghr_q; found = 1'b0; ghr_fetch = ghr_q;
    cond = 1'b0; unc = 1'b0; dec = 1'b0; hit = 1'b0; opc = '0; pi = '0; bi = '0;
    take_branch_out = '0; inst_valid_out = '0; ghr_out = '0;
    take_branch_target_out = if_NPC_out[NUM_SUPER-1];
    for (int i = 0; i < NUM_SUPER; i++) begin
      ghr_out[i] = h;
      opc  = if_IR_out[i][31:26];
      cond = (opc >= OP_BLBC) && (opc <= OP_BGT);
      unc  = (opc == OP_BR) || (opc == OP_BSR) || (opc == OP_JSR);
      dec  = if_valid[i] && !rb_en;
      pi   = if_NPC_out[i][PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(h);
      bi   = if_NPC_out[i][BTB_IDX_BITS+1:2];
      hit  = btb_v_q[bi] &&
             (btb_tag_q[bi] == if_NPC_out[i][BTB_IDX_BITS+BTB_TAG_BITS+1:BTB_IDX_BITS+2]);
      take_branch_out[i] = dec && hit && (unc || (cond && pht_q[pi][1]));
      inst_valid_out[i]  = dec && !found;
      if (!found) begin
        if (dec && cond) ghr_fetch = {ghr_fetch[GHR_BITS-2:0], take_branch_out[i]};
        if (take_branch_out[i]) begin
          found = 1'b1;
          take_branch_target_out = btb_tgt_q[bi];
        end
      end
      if (dec && cond) h = {h[GHR_BITS-2:0], 1'b0};
    end
    if (rb_en) take_branch_target_out = rb_target;
  end

  // Next history and training enables; branches younger than the winner are squashed.
  always_comb begin
    if (rb_en) ghr_d = win_cond ? {win_ghr[GHR_BITS-2:0], win_taken} : win_ghr;
    else       ghr_d = ghr_fetch;
    br_train = '0;
    for (int k = 0; k < NUM_BR; k++)
      br_train[k] = br_done[k] && !(rb_en && (br_dist[k] < win_dist));
  end

  // State update; later ports overwrite earlier ones on index collisions.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ghr_q <= '0;
      for (int i = 0; i < 2**PHT_IDX_BITS; i++) pht_q[i] <= 2'b01;
      for (int i = 0; i < 2**BTB_IDX_BITS; i++) btb_v_q[i] <= 1'b0;
    end else begin
      ghr_q <= ghr_d;
      for (int k = 0; k < NUM_BR; k++) begin
        if (br_train[k]) begin
          if (br_is_cond[k])
            pht_q[br_pht_idx[k]] <= sat2(pht_q[br_pht_idx[k]], br_taken[k]);
          if (br_taken[k]) begin
            btb_v_q[br_btb_idx[k]]   <= 1'b1;
            btb_tag_q[br_btb_idx[k]] <= br_tag[k];
            btb_tgt_q[br_btb_idx[k]] <= br_target_PC[k];
          end
        end
      end
    end
  end

endmodule
